// File: rtl/eth_tx_min_frame_pad.sv
// Pads short AXI4-Stream frames with zeros up to MIN_FRAME_BYTES (excluding FCS)
// ahead of the 10G TX FIFO. Frames at or above the minimum pass through unchanged.
module eth_tx_min_frame_pad #(
   parameter int MIN_FRAME_BYTES = 60,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 user_clk,
   input  logic                 aresetn,
   input  logic [63:0]          s_axis_tdata,
   input  logic [7:0]           s_axis_tkeep,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [63:0]          m_axis_tdata,
   output logic [7:0]           m_axis_tkeep,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   input  logic                 m_axis_tready,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] pad_count
);

   typedef enum logic {IDLE, PAD} state_t;

   localparam logic [16:0] MIN_17 = 17'(MIN_FRAME_BYTES);
   localparam logic [15:0] MIN_16 = 16'(MIN_FRAME_BYTES);

   state_t      state;
   logic [15:0] byte_cnt;
   logic        load;
   logic        accept;
   logic [3:0]  beat_bytes;
   logic [16:0] sum;
   logic [15:0] sum_sat;
   logic [15:0] rem;
   logic        rem_small;
   logic [7:0]  rem_keep;
   logic [63:0] masked_data;

   // The output register may load when empty or when its content leaves this cycle.
   assign load          = ~m_axis_tvalid | m_axis_tready;
   assign s_axis_tready = aresetn & (state == IDLE) & load;
   assign accept        = s_axis_tvalid & s_axis_tready;

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < 8; i++) begin
         beat_bytes = beat_bytes + 4'(s_axis_tkeep[i]);
      end
   end

   assign sum       = {1'b0, byte_cnt} + 17'(beat_bytes);
   assign sum_sat   = sum[16] ? 16'hFFFF : sum[15:0];
   // Only meaningful while byte_cnt is below the minimum, which holds whenever it is used.
   assign rem       = MIN_16 - byte_cnt;
   assign rem_small = (rem <= 16'd8);

   always_comb begin
      rem_keep = '0;
      for (int i = 0; i < 8; i++) begin
         rem_keep[i] = (rem > 16'(i));
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane_mask
         assign masked_data[gi*8 +: 8] = s_axis_tdata[gi*8 +: 8] & {8{s_axis_tkeep[gi]}};
      end
   endgenerate

   always_ff @(posedge user_clk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         frame_count   <= '0;
         pad_count     <= '0;
      end else begin
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count <= frame_count + CNT_WIDTH'(1);
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  m_axis_tvalid <= 1'b1;
                  if (!s_axis_tlast) begin
                     m_axis_tdata <= s_axis_tdata;
                     m_axis_tkeep <= s_axis_tkeep;
                     m_axis_tlast <= 1'b0;
                     byte_cnt     <= sum_sat;
                  end else if (sum >= MIN_17) begin
                     m_axis_tdata <= s_axis_tdata;
                     m_axis_tkeep <= s_axis_tkeep;
                     m_axis_tlast <= 1'b1;
                     byte_cnt     <= '0;
                  end else begin
                     // Short frame: unused lanes become the first pad bytes.
                     m_axis_tdata <= masked_data;
                     if (rem_small) begin
                        m_axis_tkeep <= rem_keep;
                        m_axis_tlast <= 1'b1;
                        byte_cnt     <= '0;
                        pad_count    <= pad_count + CNT_WIDTH'(1);
                     end else begin
                        m_axis_tkeep <= 8'hFF;
                        m_axis_tlast <= 1'b0;
                        byte_cnt     <= byte_cnt + 16'd8;
                        state        <= PAD;
                     end
                  end
               end else if (load) begin
                  m_axis_tvalid <= 1'b0;
               end
            end

            PAD: begin
               if (load) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= '0;
                  if (rem_small) begin
                     m_axis_tkeep <= rem_keep;
                     m_axis_tlast <= 1'b1;
                     byte_cnt     <= '0;
                     pad_count    <= pad_count + CNT_WIDTH'(1);
                     state        <= IDLE;
                  end else begin
                     m_axis_tkeep <= 8'hFF;
                     m_axis_tlast <= 1'b0;
                     byte_cnt     <= byte_cnt + 16'd8;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/eth_tx_min_frame_pad.md
Name: eth_tx_min_frame_pad

Overview:
- AXI4-Stream 64-bit stage directly upstream of the 10G TX interface FIFO.
- Guarantees every frame handed toward the XGMAC carries at least MIN_FRAME_BYTES bytes, excluding FCS.
- Short frames are zero-padded at the tail; frames at or above the minimum pass through unchanged.
- One registered output stage; full throughput on pass-through traffic.

Parameters:
- MIN_FRAME_BYTES, 60, minimum frame length in bytes excluding FCS; legal range 9..1514.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- user_clk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  64  frame data from the application; byte 0 in bits [7:0].
- s_axis_tkeep  in  8  byte enables; contiguous from bit 0; all-ones on every non-last beat.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  64  data toward the TX interface.
- m_axis_tkeep  out  8  byte enables toward the TX interface.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  output last.
- m_axis_tready  in  1  downstream accept.
- frame_count  out  CNT_WIDTH  frames emitted, counted on the output tlast handshake; wraps.
- pad_count  out  CNT_WIDTH  frames that needed padding; wraps.

Behaviour:
- Reset (aresetn low, asynchronous):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0.
  - Counters=0, byte_cnt=0, state=IDLE.
  - s_axis_tready=0 while aresetn is low.
- Reset mid-frame: the partial frame is discarded with no tlast emitted. The next accepted beat starts a new frame.
- Output register handshake:
  - The register loads when it is empty or m_axis_tready=1 in the same cycle.
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* signals hold stable.
- s_axis_tready = (state==IDLE) & (~m_axis_tvalid | m_axis_tready).
- Latency: one cycle, input handshake to m_axis_tvalid.
- Bytes per beat: n = number of set tkeep bits, 0..8. A tkeep=0 beat contributes 0 bytes. byte_cnt is 16 bits and saturates at 0xFFFF.
- State IDLE, beat accepted:
  - tlast=0:
    - Forward the beat unchanged.
    - byte_cnt <= byte_cnt+n.
  - tlast=1 and byte_cnt+n >= MIN_FRAME_BYTES:
    - Forward the beat unchanged.
    - byte_cnt <= 0.
  - tlast=1 and byte_cnt+n < MIN_FRAME_BYTES, with rem = MIN_FRAME_BYTES - byte_cnt:
    - Output data: byte lanes with tkeep=0 are forced to 0x00.
    - If rem <= 8: tkeep = (1<<rem)-1, tlast=1, byte_cnt <= 0, pad_count++.
    - If rem > 8: tkeep=0xFF, tlast=0, byte_cnt <= byte_cnt+8, go to PAD.
- State PAD (input stalled):
  - Each cycle the output register loads, emit tdata=0, with rem = MIN_FRAME_BYTES - byte_cnt.
  - If rem > 8: tkeep=0xFF, tlast=0, byte_cnt += 8.
  - Otherwise: tkeep=(1<<rem)-1, tlast=1, byte_cnt <= 0, pad_count++, go to IDLE.
- frame_count increments on the m_axis handshake with tlast=1.
- Counters wrap at 2^CNT_WIDTH.
- No minimum idle time between frames: a new frame's first beat may be accepted in the same cycle the previous frame's last beat handshakes out.
- Oversized frames are passed through unmodified; this block does not enforce a maximum length.

Test Plan:
- 60-byte frame (7 beats keep 0xFF, then keep 0x0F tlast), m_axis_tready=1:
  - Output identical, 8 beats back-to-back, 1-cycle latency.
  - frame_count=1, pad_count=0.
- Single beat, keep 0x07, tlast, data 0xFFFFFFFFFFAABBCC:
  - Beat0: data 0x0000000000AABBCC, keep 0xFF.
  - Then 6 zero beats keep 0xFF.
  - Then a zero beat with keep 0x0F, tlast. Total 60 bytes.
  - s_axis_tready low for 7 cycles; pad_count=1.
- 57-byte frame (last beat keep 0x01, tlast):
  - Last output beat keep 0x0F, lanes 1..3 zero, tlast, 8 beats total.
  - pad_count=1.
- 64-byte frame with m_axis_tready toggling 1,0,0,1 continuously:
  - No beat lost or duplicated; m_axis_* stable whenever tready=0.
  - Output equals input.
- Two back-to-back 8-byte frames:
  - Each produces 8 output beats ending in keep 0x0F tlast.
  - The second frame's first beat is accepted the cycle after the first frame's pad tlast loads.
  - frame_count=2.
- aresetn asserted during the 3rd beat of a 100-byte frame, released after 2 cycles, then a 60-byte frame sent:
  - During reset: m_axis_tvalid=0, counters=0.
  - After release: the 60-byte frame is output unchanged; frame_count=1.
